tdm_demux_1to4: RTL and testbench
=================================

# tdm_demux_1to4

Four-channel time-division demultiplexer: the receive end of a TDM link whose transmit end is a 4-to-1 multiplexer cycling through inputs I0..I3. It receives one beat per slot on a single data line, locks onto the frame marker, collects four slots into a shadow buffer, and presents all four channels together on registered outputs with a one-cycle frame strobe. Framing errors are flagged and counted, and the block resynchronises automatically.

## Interface
- WIDTH, 1: bits per slot beat and per channel output.
- CNT_W, 8: width of the saturating error counter.

- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- DIN  input  WIDTH  slot data from the TDM line.
- DIN_VALID  input  1  DIN holds a slot beat this cycle.
- FRAME_SYNC  input  1  qualified by DIN_VALID; marks the beat as slot 0 (channel 0).
- OUT0..OUT3  output  WIDTH each  last complete frame, channels 0..3.
- FRAME_VALID  output  1  one-cycle pulse when OUT0..OUT3 have just been updated.
- LOCKED  output  1  high while the block is in the LOCK state.
- SLOT  output  2  index of the next expected slot.
- SYNC_ERR  output  1  one-cycle pulse on any framing error.
- ERR_COUNT  output  CNT_W  saturating count of SYNC_ERR pulses.

## Operation
- State machine states:
  - HUNT (reset state).
  - LOCK.
- Beat definition: a beat is a cycle with DIN_VALID=1. Cycles with DIN_VALID=0 change no state and no register. FRAME_SYNC is ignored on those cycles.
- HUNT:
  - A beat with FRAME_SYNC=0 is discarded. No error is raised.
  - A beat with FRAME_SYNC=1 stores DIN in shadow[0], sets SLOT=1 and moves to LOCK.
- LOCK, beat with FRAME_SYNC=0:
  - SLOT=1 or 2: store DIN in shadow[SLOT] and increment SLOT.
  - SLOT=3: load OUT0..OUT2 from shadow[0..2] and OUT3 from DIN in the same edge. Set FRAME_VALID for the next cycle. SLOT wraps to 0. Stay in LOCK.
  - SLOT=0: missing marker. Pulse SYNC_ERR, discard the beat, go to HUNT, SLOT=0.
- LOCK, beat with FRAME_SYNC=1:
  - SLOT=0: normal frame start. Store DIN in shadow[0] and set SLOT=1.
  - SLOT=1..3: early marker. Pulse SYNC_ERR and drop the partial frame; OUT0..OUT3 are not updated. Treat the beat as slot 0: store it in shadow[0], set SLOT=1, stay in LOCK.
- Outputs hold:
  - OUT0..OUT3 change only on a completed frame and otherwise hold their value indefinitely.
  - Shadow contents from an aborted frame are never exposed.
- ERR_COUNT:
  - Increments by 1 on each SYNC_ERR.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Clears only on reset.
- LOCKED=1 exactly when the state is LOCK.

## Timing
- Reset values (asynchronous, take effect immediately on RST rise):
  - State HUNT, LOCKED=0, SLOT=0.
  - OUT0..OUT3=0, shadow=0.
  - FRAME_VALID=0, SYNC_ERR=0, ERR_COUNT=0.
- Reset mid-frame discards the partial frame. After RST falls, the first beat can be processed at the first rising edge.
- All outputs are registered, with no combinational path from input to output.
- Latency: the slot-3 beat sampled at edge N makes OUT0..OUT3 and FRAME_VALID visible after edge N. FRAME_VALID falls after edge N+1 unless another frame completes at N+1, which is impossible because a frame needs at least 4 beats.
- SYNC_ERR is high for the one cycle following the edge that sampled the offending beat.
- ERR_COUNT updates on that same edge.
- Back-to-back beats (DIN_VALID held high) are supported with no bubbles, giving at most one frame every 4 cycles.
- Idle gaps of any length between beats are allowed and are not errors.

## Test plan
- Reset, then beats 1,0,1,0 (WIDTH=1) with FRAME_SYNC on the first beat, back-to-back -> OUT0..3 = 1,0,1,0, a single FRAME_VALID pulse one cycle after the 4th beat, LOCKED=1, SYNC_ERR never asserted.
- Same frame with DIN_VALID=0 gaps of 0..3 cycles inserted randomly, followed by a second frame 0,1,1,0 -> two FRAME_VALID pulses, final OUT0..3 = 0,1,1,0, outputs stable between pulses.
- In HUNT, 5 beats without FRAME_SYNC, then a valid frame -> no error and ERR_COUNT=0; the first 5 beats are ignored and the frame is delivered correctly.
- While locked, FRAME_SYNC on the 3rd beat (SLOT=2), then 3 more beats -> SYNC_ERR pulse, ERR_COUNT=1, OUT unchanged at the abort, the resynced frame is delivered 3 beats later with its first beat as OUT0.
- While locked, a frame-start beat without FRAME_SYNC -> SYNC_ERR, LOCKED=0, beat dropped; the next FRAME_SYNC relocks. With CNT_W=2, five such errors -> ERR_COUNT saturates at 3.
- Assert RST after the 2nd beat of a frame -> all outputs return to their reset values immediately; post-reset frame 0,0,1,1 -> OUT0..3 = 0,0,1,1 with no leftover data from the aborted frame.

Source files
------------

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4
// Receive end of a four-slot TDM link. Hunts for the frame marker, collects
// slots 0..2 into a shadow buffer and publishes all four channels together
// when the slot-3 beat arrives. Framing errors pulse sync_err, bump a
// saturating counter and force a resynchronisation.
module tdm_demux_1to4 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             frame_valid,
  output logic             locked,
  output logic [1:0]       slot,
  output logic             sync_err,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r;
  state_t           state_s;
  logic [1:0]       slot_s;
  logic [WIDTH-1:0] sh0_r, sh1_r, sh2_r;
  logic [WIDTH-1:0] sh0_s, sh1_s, sh2_s;
  logic [WIDTH-1:0] out0_s, out1_s, out2_s, out3_s;
  logic             fv_s;
  logic             err_s;
  logic [CNT_W-1:0] cnt_s;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= HUNT;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, slot tracking, shadow capture and frame publication.
  always_comb begin
    state_s = state_r;
    slot_s  = slot;
    sh0_s   = sh0_r;
    sh1_s   = sh1_r;
    sh2_s   = sh2_r;
    out0_s  = out0;
    out1_s  = out1;
    out2_s  = out2;
    out3_s  = out3;
    fv_s    = 1'b0;
    err_s   = 1'b0;
    if (din_valid) begin
      case (state_r)
        HUNT: begin
          if (frame_sync) begin
            sh0_s   = din;
            slot_s  = 2'd1;
            state_s = LOCK;
          end else begin
            state_s = HUNT;
          end
        end
        LOCK: begin
          if (frame_sync) begin
            // A marker anywhere but slot 0 aborts the partial frame; the
            // marker beat itself starts the new one.
            err_s  = (slot != 2'd0);
            sh0_s  = din;
            slot_s = 2'd1;
          end else begin
            case (slot)
              2'd0: begin
                err_s   = 1'b1;
                state_s = HUNT;
                slot_s  = 2'd0;
              end
              2'd1: begin
                sh1_s  = din;
                slot_s = 2'd2;
              end
              2'd2: begin
                sh2_s  = din;
                slot_s = 2'd3;
              end
              2'd3: begin
                // Slot 3 bypasses the shadow so the frame lands in one edge.
                out0_s = sh0_r;
                out1_s = sh1_r;
                out2_s = sh2_r;
                out3_s = din;
                fv_s   = 1'b1;
                slot_s = 2'd0;
              end
              default: begin
                slot_s = 2'd0;
              end
            endcase
          end
        end
        default: begin
          state_s = HUNT;
          slot_s  = 2'd0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
    if (err_s && (err_count != CNT_MAX)) begin
      cnt_s = err_count + CNT_W'(1);
    end else begin
      cnt_s = err_count;
    end
  end

  // Datapath and status registers; every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot        <= 2'd0;
      locked      <= 1'b0;
      sh0_r       <= '0;
      sh1_r       <= '0;
      sh2_r       <= '0;
      out0        <= '0;
      out1        <= '0;
      out2        <= '0;
      out3        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      err_count   <= '0;
    end else begin
      slot        <= slot_s;
      locked      <= (state_s == LOCK);
      sh0_r       <= sh0_s;
      sh1_r       <= sh1_s;
      sh2_r       <= sh2_s;
      out0        <= out0_s;
      out1        <= out1_s;
      out2        <= out2_s;
      out3        <= out3_s;
      frame_valid <= fv_s;
      sync_err    <= err_s;
      err_count   <= cnt_s;
    end
  end

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Scoreboard bench for tdm_demux_1to4: a queue-based frame model predicts
// per-cycle status and delivered frames; a monitor compares after each edge.
module tb_tdm_demux_1to4;

  localparam int W     = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic           fv;
    logic           err;
    logic           lk;
    logic [1:0]     sl;
    logic [CNT_W-1:0] cnt;
    logic [4*W-1:0] outs;
  } st_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] out0, out1, out2, out3;
  logic         frame_valid, locked, sync_err;
  logic [1:0]   slot;
  logic [CNT_W-1:0] err_count;

  tdm_demux_1to4 #(.WIDTH(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .frame_sync(frame_sync), .out0(out0), .out1(out1), .out2(out2),
    .out3(out3), .frame_valid(frame_valid), .locked(locked), .slot(slot),
    .sync_err(sync_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state: beats of the frame being collected, lock flag,
  // last published frame and error count.
  logic [W-1:0]   part[$];
  bit             mlocked = 1'b0;
  logic [4*W-1:0] mout = '0;
  int             mcnt = 0;

  st_t            st_q[$];
  logic [4*W-1:0] fr_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    part.delete();
    mlocked = 1'b0;
    mout    = '0;
    mcnt    = 0;
    st_q.delete();
    fr_q.delete();
  endtask

  // Apply one cycle's inputs to the model and predict the post-edge status.
  task automatic model_step(input logic v, input logic fs, input logic [W-1:0] d, output st_t s);
    int n;
    s.fv  = 1'b0;
    s.err = 1'b0;
    if (v) begin
      if (!mlocked) begin
        if (fs) begin
          part.delete();
          part.push_back(d);
          mlocked = 1'b1;
        end
      end else if (fs) begin
        if (part.size() != 0) s.err = 1'b1;
        part.delete();
        part.push_back(d);
      end else if (part.size() == 0) begin
        s.err   = 1'b1;
        mlocked = 1'b0;
      end else begin
        part.push_back(d);
        if (part.size() == 4) begin
          mout = {part[3], part[2], part[1], part[0]};
          s.fv = 1'b1;
          fr_q.push_back(mout);
          part.delete();
        end
      end
    end
    if (s.err && mcnt < CMAX) mcnt++;
    n      = part.size();
    s.lk   = mlocked;
    s.sl   = n[1:0];
    s.cnt  = mcnt[CNT_W-1:0];
    s.outs = mout;
  endtask

  task automatic cyc(input logic v, input logic fs, input logic [W-1:0] d);
    st_t s;
    @(negedge clk);
    din_valid  = v;
    frame_sync = fs;
    din        = d;
    model_step(v, fs, d, s);
    st_q.push_back(s);
  endtask

  task automatic beat(input logic fs, input logic [W-1:0] d);
    cyc(1'b1, fs, d);
  endtask

  task automatic gap_beat(input logic fs, input logic [W-1:0] d);
    repeat ($urandom_range(0, 3)) cyc(1'b0, 1'($urandom), W'($urandom));
    beat(fs, d);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    din_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check({nm, "_outs"}, {48'd0, out3, out2, out1, out0}, 64'd0);
    check({nm, "_flags"}, {59'd0, frame_valid, sync_err, locked, slot}, 64'd0);
    check({nm, "_cnt"}, {62'd0, err_count}, 64'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: per-cycle status against the model, frames popped on frame_valid.
  always begin
    st_t e, a;
    logic [4*W-1:0] f;
    @(posedge clk);
    #1;
    if (st_q.size() > 0) begin
      e = st_q.pop_front();
      a = {frame_valid, sync_err, locked, slot, err_count, out3, out2, out1, out0};
      check("status", 64'(a), 64'(e));
      if (frame_valid) begin
        if (fr_q.size() == 0) begin
          check("frame_unexpected", 64'(frame_valid), 64'd0);
        end else begin
          f = fr_q.pop_front();
          check("frame", {48'd0, out3, out2, out1, out0}, 64'(f));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("reset");

    // Hunt: five beats without marker are ignored, then a frame.
    repeat (5) beat(1'b0, W'($urandom));
    beat(1'b1, 4'h3); beat(1'b0, 4'h5); beat(1'b0, 4'h9); beat(1'b0, 4'hC);

    // Back-to-back frame 1,0,1,0.
    beat(1'b1, 4'd1); beat(1'b0, 4'd0); beat(1'b0, 4'd1); beat(1'b0, 4'd0);

    // Same frame with idle gaps, then 0,1,1,0.
    gap_beat(1'b1, 4'd1); gap_beat(1'b0, 4'd0); gap_beat(1'b0, 4'd1); gap_beat(1'b0, 4'd0);
    gap_beat(1'b1, 4'd0); gap_beat(1'b0, 4'd1); gap_beat(1'b0, 4'd1); gap_beat(1'b0, 4'd0);
    repeat (3) cyc(1'b0, 1'b0, 4'd0);

    // Early marker on slot 2, then three more beats complete the resynced frame.
    beat(1'b1, 4'hA); beat(1'b0, 4'hB);
    beat(1'b1, 4'h6); beat(1'b0, 4'h7); beat(1'b0, 4'h8); beat(1'b0, 4'hE);

    // Five missing-marker errors with relock in between; counter saturates.
    repeat (5) begin
      beat(1'b0, 4'hF);
      beat(1'b1, W'($urandom)); beat(1'b0, W'($urandom));
      beat(1'b0, W'($urandom)); beat(1'b0, W'($urandom));
    end

    // Reset after two beats of a frame, then frame 0,0,1,1.
    beat(1'b1, 4'hD); beat(1'b0, 4'h4);
    do_reset("midreset");
    beat(1'b1, 4'd0); beat(1'b0, 4'd0); beat(1'b0, 4'd1); beat(1'b0, 4'd1);

    // Random traffic: mostly well-formed frames with occasional misplaced markers.
    for (int i = 0; i < 300; i++) begin
      logic v, fs;
      v  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 4) == 0);
      cyc(v, fs, W'($urandom));
    end

    repeat (3) cyc(1'b0, 1'b0, 4'd0);
    @(negedge clk);
    check("drain", {32'd0, 16'(st_q.size()), 16'(fr_q.size())}, 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
